// File: rtl/main_control_fsm_if.sv
// rtl/main_control_fsm_if.sv - instruction fields in, per-cycle controls out of the main controller
interface main_control_fsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCS;
  logic [1:0] FlagW;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    output Op, Funct, Rd,
    input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           NextPC, RegW, MemW, PCS, FlagW, Illegal, State
  );

  modport slave (
    input  Op, Funct, Rd,
    output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl,
           NextPC, RegW, MemW, PCS, FlagW, Illegal, State
  );
endinterface

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle fetch/decode/execute/memory/writeback controller
module main_control_fsm (
  input  logic               clk,
  input  logic               reset,
  main_control_fsm_if.slave  bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cmd;
  logic [1:0] alu_ctl, flag_dec;
  logic       no_write, arith_cmd;

  logic       ir_write_q, adr_src_q, alu_src_a_q, next_pc_q, reg_w_q, mem_w_q, branch_q, alu_op_q;
  logic [1:0] alu_src_b_q, result_src_q;
  logic       ir_write_d, adr_src_d, alu_src_a_d, next_pc_d, reg_w_d, mem_w_d, branch_d, alu_op_d;
  logic [1:0] alu_src_b_d, result_src_d;

  assign cmd = bus.Funct[4:1];

  always_comb begin
    alu_ctl   = 2'b00;
    no_write  = 1'b0;
    arith_cmd = 1'b0;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; arith_cmd = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; arith_cmd = 1'b1; end
      4'b0000: alu_ctl = 2'b10;
      4'b1100: alu_ctl = 2'b11;
      4'b1010: begin alu_ctl = 2'b01; arith_cmd = 1'b1; no_write = 1'b1; end
      default: alu_ctl = 2'b00;
    endcase
    flag_dec = {bus.Funct[0], bus.Funct[0] & arith_cmd};
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b01:   state_nxt = MEMADR;
          2'b00:   state_nxt = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = MEMWB;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  // Outputs are registered from the state being entered; ALUWB's RegW captures NoWrite on the same edge.
  always_comb begin
    ir_write_d   = 1'b0;
    adr_src_d    = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 2'b00;
    result_src_d = 2'b00;
    next_pc_d    = 1'b0;
    reg_w_d      = 1'b0;
    mem_w_d      = 1'b0;
    branch_d     = 1'b0;
    alu_op_d     = 1'b0;
    case (state_nxt)
      FETCH: begin
        ir_write_d = 1'b1; alu_src_a_d = 1'b1; alu_src_b_d = 2'b10;
        result_src_d = 2'b10; next_pc_d = 1'b1;
      end
      DECODE: begin
        alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; result_src_d = 2'b10;
      end
      MEMADR:   alu_src_b_d = 2'b01;
      MEMREAD:  adr_src_d = 1'b1;
      MEMWB:    begin result_src_d = 2'b01; reg_w_d = 1'b1; end
      MEMWRITE: begin adr_src_d = 1'b1; mem_w_d = 1'b1; end
      EXECUTER: alu_op_d = 1'b1;
      EXECUTEI: begin alu_src_b_d = 2'b01; alu_op_d = 1'b1; end
      ALUWB:    reg_w_d = ~no_write;
      BRANCH:   begin alu_src_b_d = 2'b01; result_src_d = 2'b10; branch_d = 1'b1; end
      default:  ir_write_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FETCH;
      ir_write_q   <= 1'b1;
      adr_src_q    <= 1'b0;
      alu_src_a_q  <= 1'b1;
      alu_src_b_q  <= 2'b10;
      result_src_q <= 2'b10;
      next_pc_q    <= 1'b1;
      reg_w_q      <= 1'b0;
      mem_w_q      <= 1'b0;
      branch_q     <= 1'b0;
      alu_op_q     <= 1'b0;
    end else begin
      state        <= state_nxt;
      ir_write_q   <= ir_write_d;
      adr_src_q    <= adr_src_d;
      alu_src_a_q  <= alu_src_a_d;
      alu_src_b_q  <= alu_src_b_d;
      result_src_q <= result_src_d;
      next_pc_q    <= next_pc_d;
      reg_w_q      <= reg_w_d;
      mem_w_q      <= mem_w_d;
      branch_q     <= branch_d;
      alu_op_q     <= alu_op_d;
    end
  end

  // Enables are gated by reset so an abort kills them without waiting for an edge.
  assign bus.IRWrite    = ir_write_q & reset;
  assign bus.NextPC     = next_pc_q & reset;
  assign bus.RegW       = reg_w_q & reset;
  assign bus.MemW       = mem_w_q & reset;
  assign bus.PCS        = reset & (branch_q | (reg_w_q & (bus.Rd == 4'hF)));
  assign bus.FlagW      = (alu_op_q & reset) ? flag_dec : 2'b00;
  assign bus.ALUControl = alu_op_q ? alu_ctl : 2'b00;
  assign bus.Illegal    = reset & (state == DECODE) & (bus.Op == 2'b11);
  assign bus.AdrSrc     = adr_src_q;
  assign bus.ALUSrcA    = alu_src_a_q;
  assign bus.ALUSrcB    = alu_src_b_q;
  assign bus.ResultSrc  = result_src_q;
  assign bus.State      = state;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - table, hand-written and random checks of main_control_fsm
module tb_main_control_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_control_fsm_if bus ();
  main_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic       ir, adr, srca;
    logic [1:0] srcb, res, aluc;
    logic       npc, regw, memw, pcs;
    logic [1:0] flagw;
    logic       ill;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    int          n;
    logic [23:0] path;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   exp_path[$];
  vec_t tbl[10];

  function automatic obs_t sample();
    obs_t g;
    g.ir = bus.IRWrite; g.adr = bus.AdrSrc; g.srca = bus.ALUSrcA; g.srcb = bus.ALUSrcB;
    g.res = bus.ResultSrc; g.aluc = bus.ALUControl; g.npc = bus.NextPC; g.regw = bus.RegW;
    g.memw = bus.MemW; g.pcs = bus.PCS; g.flagw = bus.FlagW; g.ill = bus.Illegal; g.st = bus.State;
    return g;
  endfunction

  // Expected outputs of one cycle, straight from the per-state output rules.
  function automatic obs_t model(int st, logic [1:0] op, logic [5:0] funct, logic [3:0] rd);
    obs_t o;
    logic [3:0] c;
    logic arith;
    o = '0;
    o.st = 4'(st);
    c = funct[4:1];
    arith = (c == 4'b0100) || (c == 4'b0010) || (c == 4'b1010);
    case (st)
      0: begin o.ir = 1; o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; o.npc = 1; end
      1: begin o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; o.ill = (op == 2'b11); end
      2: o.srcb = 2'b01;
      3: o.adr = 1;
      4: begin o.res = 2'b01; o.regw = 1; end
      5: begin o.adr = 1; o.memw = 1; end
      6, 7: begin
        o.srcb = (st == 7) ? 2'b01 : 2'b00;
        if (c == 4'b0010 || c == 4'b1010) o.aluc = 2'b01;
        else if (c == 4'b0000) o.aluc = 2'b10;
        else if (c == 4'b1100) o.aluc = 2'b11;
        else o.aluc = 2'b00;
        o.flagw = {funct[0], funct[0] & arith};
      end
      8: o.regw = (c != 4'b1010);
      9: begin o.srcb = 2'b01; o.res = 2'b10; o.pcs = 1; end
      default: o = '0;
    endcase
    if (o.regw && rd == 4'hF) o.pcs = 1;
    return o;
  endfunction

  function automatic void make_path(logic [1:0] op, logic [5:0] funct);
    exp_path = {0, 1};
    case (op)
      2'b01: if (funct[0]) exp_path = {0, 1, 2, 3, 4}; else exp_path = {0, 1, 2, 5};
      2'b00: exp_path = {0, 1, funct[5] ? 7 : 6, 8};
      2'b10: exp_path = {0, 1, 9};
      default: exp_path = {0, 1};
    endcase
  endfunction

  task automatic check(obs_t exp, string name, int cyc);
    obs_t got;
    got = sample();
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.srca = 1; o.srcb = 2'b10; o.res = 2'b10;
    return o;
  endfunction

  // Called mid-cycle while in FETCH; walks exp_path and returns mid-cycle back in FETCH.
  task automatic run_instr(logic [1:0] op, logic [5:0] funct, logic [3:0] rd, string name);
    bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    foreach (exp_path[i]) begin
      check(model(exp_path[i], op, funct, rd), name, i);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0] = '{2'b01, 6'b011001, 4'd3,  5, 24'h043210};
    tbl[1] = '{2'b01, 6'b011000, 4'd0,  4, 24'h005210};
    tbl[2] = '{2'b00, 6'b010101, 4'd0,  4, 24'h008610};
    tbl[3] = '{2'b00, 6'b101001, 4'd15, 4, 24'h008710};
    tbl[4] = '{2'b10, 6'b000000, 4'd0,  3, 24'h000910};
    tbl[5] = '{2'b11, 6'b000000, 4'd0,  2, 24'h000010};
    tbl[6] = '{2'b00, 6'b000001, 4'd2,  4, 24'h008610};
    tbl[7] = '{2'b00, 6'b111000, 4'd15, 4, 24'h008710};
    tbl[8] = '{2'b01, 6'b011001, 4'd15, 5, 24'h043210};
    tbl[9] = '{2'b00, 6'b011011, 4'd4,  4, 24'h008610};

    reset = 1'b0;
    bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0;
    #12;
    check(reset_obs(), "reset_hold", 0);
    @(negedge clk); reset = 1'b1; #1;
    check(model(0, 2'b00, 6'b0, 4'd0), "release_fetch", 0);

    foreach (tbl[k]) begin
      exp_path = {};
      for (int i = 0; i < tbl[k].n; i++) exp_path.push_back(int'(tbl[k].path[4*i +: 4]));
      run_instr(tbl[k].op, tbl[k].funct, tbl[k].rd, $sformatf("tbl%0d", k));
    end
    check(model(0, 2'b00, 6'b0, 4'd0), "tbl_end_fetch", 0);

    // Reset during EXECUTER: immediate FETCH with enables off, full enables once released.
    bus.Op = 2'b00; bus.Funct = 6'b010101; bus.Rd = 4'd1;
    @(posedge clk); #1; @(posedge clk); #1;
    check(model(6, 2'b00, 6'b010101, 4'd1), "pre_abort_exec", 0);
    #2 reset = 1'b0; #1;
    check(reset_obs(), "abort_exec", 0);
    #1 reset = 1'b1; #1;
    check(model(0, 2'b00, 6'b0, 4'd0), "abort_exec_release", 0);
    @(posedge clk); #1;
    check(model(1, 2'b00, 6'b010101, 4'd1), "abort_exec_decode", 0);
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    check(model(0, 2'b00, 6'b0, 4'd0), "abort_exec_refetch", 0);

    // Reset during MEMWRITE drops MemW without an edge.
    bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'd2;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check(model(5, 2'b01, 6'b011000, 4'd2), "pre_abort_store", 0);
    #2 reset = 1'b0; #1;
    check(reset_obs(), "abort_store", 0);
    #1 reset = 1'b1; #1;
    check(model(0, 2'b00, 6'b0, 4'd0), "abort_store_release", 0);

    // NoWrite is held through ALUWB even if Funct moves.
    exp_path = {0, 1, 6};
    run_instr(2'b00, 6'b010101, 4'd15, "cmp_latch");
    bus.Funct = 6'b001000;
    check(model(8, 2'b00, 6'b010101, 4'd15), "cmp_latch_aluwb", 0);
    @(posedge clk); #1;

    for (int r = 0; r < 80; r++) begin
      logic [1:0] op;
      logic [5:0] funct;
      logic [3:0] rd;
      op = 2'($urandom_range(0, 3));
      funct = 6'($urandom);
      rd = 4'($urandom);
      make_path(op, funct);
      run_instr(op, funct, rd, $sformatf("rand%0d", r));
    end
    check(model(0, 2'b00, 6'b0, 4'd0), "rand_end_fetch", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main controller for the ARM-subset datapath. It sits directly upstream of the conditional-logic stage. From the instruction fields it sequences fetch, decode, execute, memory and writeback, one state per clock. It emits the raw per-cycle enables (RegW, MemW, PCS, FlagW, NextPC) that the conditional logic qualifies with Cond and the stored NZCV flags, plus the datapath mux selects and the ALU control.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined
- Funct  in  6  instruction bits [25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S (DP) or L (memory)
- Rd  in  4  destination register field
- IRWrite  out  1  instruction-register load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4
- ResultSrc  out  2  00=ALUOut, 01=read data, 10=ALU result
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- NextPC  out  1  unconditional PC update (fetch)
- RegW  out  1  raw register write, to conditional logic
- MemW  out  1  raw memory write, to conditional logic
- PCS  out  1  Branch | (RegW & Rd==4'hF), to conditional logic
- FlagW  out  2  [1]=update NZ, [0]=update CV, to conditional logic
- Illegal  out  1  one-cycle pulse on undefined Op
- State  out  4  current state encoding, for debug and verification

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10-15 are unreachable and go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH with Illegal=1.
  - MEMADR: L=1 -> MEMREAD; L=0 -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
- Moore outputs per state; any signal not listed is 0.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1 unless NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode (ALUOp is internal), combinational from Funct:
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, cmd 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; 1010 CMP -> 01 with NoWrite=1.
  - Any other cmd decodes as ADD.
  - FlagW[1]=S; FlagW[0]=S & (cmd is ADD, SUB or CMP).
- NoWrite is latched at the EXECUTER/EXECUTEI -> ALUWB edge, so ALUWB does not depend on Funct changing.
- PCS is combinational from the state outputs and Rd. MEMWB or ALUWB with Rd=15 gives PCS=1. PCS is 0 in all other states except BRANCH.

## Timing
- Latency in cycles, FETCH to the next FETCH: load 5, store 4, DP 4, branch 3, undefined 2.
- Op, Funct and Rd must be stable from the cycle after FETCH until the return to FETCH. The IR holds them.
- Reset low asynchronously forces State=FETCH.
- While reset is low, IRWrite, NextPC, RegW, MemW, PCS, FlagW and Illegal are forced to 0. Mux selects show FETCH values.
- The first rising edge after reset deasserts executes FETCH with full enables.
- Reset asserted mid-instruction (e.g. in MEMWRITE) aborts immediately: MemW drops in the same cycle, with no edge required, and no write completes.
- Illegal is high only in the DECODE cycle with Op=11.

## Test plan
- Reset low during EXECUTER, then release -> State=0 immediately with all enables 0; first post-release cycle IRWrite=1, NextPC=1.
- LDR: Op=01, Funct=011001, Rd=3 -> State 0,1,2,3,4,0; RegW=1 only in state 4; PCS=0.
- STR: Op=01, Funct=011000 -> State 0,1,2,5,0; MemW=1 only in state 5; AdrSrc=1 in state 5.
- CMP R1,R2: Op=00, Funct=010101 -> EXECUTER with ALUControl=01, FlagW=11; ALUWB with RegW=0.
- ADDS R15 immediate: Op=00, Funct=101001, Rd=15 -> EXECUTEI with FlagW=11, ALUControl=00; ALUWB with RegW=1, PCS=1.
- Branch: Op=10 -> State 0,1,9,0 with PCS=1 in state 9. Undefined: Op=11 -> State 0,1,0 with Illegal=1 in state 1 only.
